seven_segment_mux_driver: RTL

//   Drives a dual common-anode seven-segment display from two hex nibbles.

---
 rtl/seven_segment_mux_driver_if.sv | 25 ++
 rtl/seven_segment_mux_driver.sv | 101 ++++++++++
 2 files changed

// File: rtl/seven_segment_mux_driver_if.sv
// Display bus between the lab datapath and the seven-segment driver:
// two hex nibbles in, shared active-low segment bus, anode enables and slot index out.
interface seven_segment_mux_driver_if;
  logic [3:0] s0;
  logic [3:0] s1;
  logic [6:0] seg;
  logic [1:0] an;
  logic       slot;

  modport master (
    output s0,
    output s1,
    input  seg,
    input  an,
    input  slot
  );

  modport slave (
    input  s0,
    input  s1,
    output seg,
    output an,
    output slot
  );
endinterface

// File: rtl/seven_segment_mux_driver.sv
// Two-digit multiplexed common-anode seven-segment driver with hex decode and
// per-slot blanking. Optional macro LEADING_ZERO_BLANK_EN hides a leading zero on digit 1.
module seven_segment_mux_driver #(
  parameter int SLOT_CYCLES  = 25000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  seven_segment_mux_driver_if.slave   bus
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt;
  logic          sel;
  logic [3:0]    dig;
  logic [6:0]    dec;
  logic [6:0]    seg_d;
  logic [1:0]    an_d;
  logic [6:0]    seg_q;
  logic [1:0]    an_q;
  logic          suppress;

  // Slot prescaler: sel flips each time a full slot of SLOT_CYCLES elapses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      sel <= 1'b0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      sel <= ~sel;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Inputs are sampled once at the start of each slot so the digit is stable for the whole slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dig <= 4'h0;
    end else if (cnt == '0) begin
      dig <= sel ? bus.s1 : bus.s0;
    end
  end

  always_comb begin
    dec = 7'b1111111;
    case (dig)
      4'h0: dec = 7'b1000000;
      4'h1: dec = 7'b1111001;
      4'h2: dec = 7'b0100100;
      4'h3: dec = 7'b0110000;
      4'h4: dec = 7'b0011001;
      4'h5: dec = 7'b0010010;
      4'h6: dec = 7'b0000010;
      4'h7: dec = 7'b1111000;
      4'h8: dec = 7'b0000000;
      4'h9: dec = 7'b0010000;
      4'hA: dec = 7'b0001000;
      4'hB: dec = 7'b0000011;
      4'hC: dec = 7'b1000110;
      4'hD: dec = 7'b0100001;
      4'hE: dec = 7'b0000110;
      4'hF: dec = 7'b0001110;
      default: dec = 7'b1111111;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign suppress = sel && (dig == 4'h0);
`else
  assign suppress = 1'b0;
`endif

  // Blanking window at each slot start keeps the old digit from ghosting onto the new anode
  always_comb begin
    seg_d = 7'b1111111;
    an_d  = 2'b11;
    if ((cnt >= BLANK) && !suppress) begin
      an_d  = sel ? 2'b01 : 2'b10;
      seg_d = dec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= 7'b1111111;
      an_q  <= 2'b11;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign bus.seg  = seg_q;
  assign bus.an   = an_q;
  assign bus.slot = sel;

endmodule
